result_select_wb: RTL

- Registered, parametrised successor to the ALU/FPU result multiplexer.
- Decodes the EX-stage opcode to one of NUM_UNITS execution units. Unit 0 is the single-cycle ALU; units 1..NUM_UNITS-1 are multi-cycle (FPU, MUL/DIV, ...).
- For multi-cycle ops: issues a start pulse, stalls the pipeline until the unit signals done, then registers the selected result and destination register toward writeback.

---
 rtl/result_select_pkg.sv | 18 +
 rtl/result_select_wb_mux.sv | 12 +
 rtl/result_select_wb.sv | 83 ++++++++
 3 files changed

// File: rtl/result_select_pkg.sv
// result_select_pkg: unit indices, opcode ranges, FSM state and opcode-to-unit decode
package result_select_pkg;
  localparam int UNIT_ALU = 0;
  localparam int UNIT_FPU = 1;
  localparam int UNIT_MDU = 2;
  localparam logic [4:0] FPU_OP_LO = 5'b01010;
  localparam logic [4:0] FPU_OP_HI = 5'b01101;
  localparam logic [4:0] MDU_OP_LO = 5'b01110;
  localparam logic [4:0] MDU_OP_HI = 5'b01111;
  typedef enum logic {IDLE, WAIT} state_t;
  // units beyond the configured count fall back to the single-cycle ALU
  function automatic int unit_of(input logic [4:0] op, input int num_units);
    int u;
    u = (op >= FPU_OP_LO && op <= FPU_OP_HI) ? UNIT_FPU :
        (op >= MDU_OP_LO && op <= MDU_OP_HI) ? UNIT_MDU : UNIT_ALU;
    return (u < num_units) ? u : UNIT_ALU;
  endfunction
endpackage

// File: rtl/result_select_wb_mux.sv
// result_slice_mux: selects one DATA_W slice of a packed per-unit result bus
module result_slice_mux #(
  parameter int DATA_W    = 32,
  parameter int NUM_UNITS = 4,
  parameter int SEL_W     = 2
) (
  input  logic [NUM_UNITS*DATA_W-1:0] data,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           y
);
  always_comb y = data[sel*DATA_W +: DATA_W];
endmodule

// File: rtl/result_select_wb.sv
// result_select_wb: registered writeback result select with multi-cycle unit start/stall handshake
// Optional abort of a hung unit after TIMEOUT_CYC WAIT cycles: define RESULT_SEL_TIMEOUT_EN.
module result_select_wb
  import result_select_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_UNITS   = 4,
  parameter int OP_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [OP_W-1:0]             i_op,
  input  logic [4:0]                  i_rd_addr,
  input  logic [NUM_UNITS*DATA_W-1:0] i_unit_data,
  input  logic [NUM_UNITS-1:0]        i_unit_done,
  output logic [NUM_UNITS-1:0]        o_unit_start,
  output logic                        o_stall,
  output logic                        o_valid,
  output logic [DATA_W-1:0]           o_result,
  output logic [4:0]                  o_rd_addr,
`ifdef RESULT_SEL_TIMEOUT_EN
  output logic                        o_timeout,
`endif
  output logic                        o_busy
);
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  state_t state, state_nx;
  logic [UW-1:0] u, u_lat, sel;
  logic [4:0] rd_lat;
  logic [DATA_W-1:0] mux_y;
  logic issue_mc, done, expired, fire;
  always_comb u = UW'(unit_of(5'(i_op), NUM_UNITS));
  assign done     = i_unit_done[u_lat];
  assign issue_mc = state == IDLE && i_valid && u != '0;
  assign fire     = (state == IDLE && i_valid && u == '0) || (state == WAIT && (done || expired));
  assign sel      = (state == WAIT) ? u_lat : '0;
`ifdef RESULT_SEL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt;
  assign expired = state == WAIT && !done && cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk) begin
    cnt       <= (i_reset || state == IDLE) ? '0 : cnt + 1'b1;
    o_timeout <= !i_reset && expired;
  end
`else
  assign expired = 1'b0;
`endif
  result_slice_mux #(.DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS), .SEL_W(UW)) u_mux (
    .data(i_unit_data),
    .sel (sel),
    .y   (mux_y)
  );
  always_ff @(posedge i_clk) state <= i_reset ? IDLE : state_nx;
  always_comb state_nx = (state == IDLE) ? (issue_mc ? WAIT : IDLE) : ((done || expired) ? IDLE : WAIT);
  // done is only looked at in WAIT, so a done in the start cycle is ignored
  always_comb begin
    o_unit_start    = '0;
    o_unit_start[u] = issue_mc && !i_reset;
    o_busy          = state == WAIT;
    o_stall         = (state == WAIT) ? !done : issue_mc;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
      u_lat     <= '0;
      rd_lat    <= '0;
    end else begin
      o_valid <= fire;
      if (fire) begin
        o_result  <= expired ? '0 : mux_y;
        o_rd_addr <= (state == WAIT) ? rd_lat : i_rd_addr;
      end
      if (issue_mc) begin
        u_lat  <= u;
        rd_lat <= i_rd_addr;
      end
    end
  end
endmodule
